// File: rtl/stopwatch_counter_if.sv
// Button inputs and timekeeping outputs of the stopwatch front end.
// The counter sits on the slave side; whoever presses buttons and watches the count is the master.
interface stopwatch_counter_if;
    logic        btn_start_stop;
    logic        btn_clear;
    logic [12:0] count;
    logic        running;
    logic        paused;
    logic        tick;
    logic        overflow;

    modport master (
        output btn_start_stop, btn_clear,
        input  count, running, paused, tick, overflow
    );

    modport slave (
        input  btn_start_stop, btn_clear,
        output count, running, paused, tick, overflow
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping: button synchronise/debounce, start/pause/clear FSM,
// one-second prescaler and elapsed-seconds counter with wrap at MAX_COUNT.
module stopwatch_counter #(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = 5999
) (
    input  logic               clk,
    input  logic               rst,
    stopwatch_counter_if.slave bus
);

    localparam int PS_W = $clog2(CLK_HZ);
    localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_HZ - 1);
    localparam logic [DC_W-1:0] DC_LAST    = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]     COUNT_LAST = 13'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // Bit 0 is start/stop, bit 1 is clear; both buttons share one identical path.
    logic [1:0]            raw;
    logic [1:0]            s1;
    logic [1:0]            s2;
    logic [1:0]            db;
    logic [1:0]            db_d;
    logic [1:0][DC_W-1:0]  dc;
    logic [1:0]            press;

    assign raw = {bus.btn_clear, bus.btn_start_stop};

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which the s1->s2 chain relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            dc   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_LAST) begin
                    db[i] <= s2[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_d;

    logic            start_ev;
    logic            clear_ev;
    state_t          state;
    logic [PS_W-1:0] prescaler;
    logic [12:0]     count;
    logic            running;
    logic            paused;
    logic            tick;
    logic            overflow;
    logic            second_done;

    assign start_ev    = press[0];
    assign clear_ev    = press[1];
    assign second_done = (state == RUNNING) && (prescaler == PS_LAST);

    // Clear overrides everything; otherwise a pending second is applied before
    // the start/stop transition so a pause on a tick edge still counts that second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            count     <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
            tick      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tick     <= 1'b0;
            overflow <= 1'b0;
            if (clear_ev) begin
                state     <= IDLE;
                prescaler <= '0;
                count     <= '0;
                running   <= 1'b0;
                paused    <= 1'b0;
            end else begin
                if (state == RUNNING) begin
                    if (second_done) begin
                        prescaler <= '0;
                        tick      <= 1'b1;
                        if (count == COUNT_LAST) begin
                            count    <= '0;
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 13'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                if (start_ev) begin
                    case (state)
                        IDLE: begin
                            state     <= RUNNING;
                            prescaler <= '0;
                            running   <= 1'b1;
                            paused    <= 1'b0;
                        end
                        RUNNING: begin
                            state   <= PAUSED;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end
                        PAUSED: begin
                            state   <= RUNNING;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                        default: begin
                            state   <= IDLE;
                            running <= 1'b0;
                            paused  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.count    = count;
    assign bus.running  = running;
    assign bus.paused   = paused;
    assign bus.tick     = tick;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random button activity,
// all compared each cycle against an elapsed-time model of the stopwatch.
module tb_stopwatch_counter;

    localparam int CLK_HZ          = 10;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int MAX_COUNT       = 5999;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MAX_COUNT       (MAX_COUNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: buttons as sample histories with a run-length filter,
    // time as total elapsed seconds plus a fraction of a second in cycles.
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;

    bit      m_s1 [2];
    bit      m_s2 [2];
    bit      m_db [2];
    bit      m_dbd[2];
    int      m_run[2];
    mstate_t m_state;
    int      m_frac;
    int      m_secs;
    bit      m_tick;
    bit      m_ovf;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b]  = 1'b0;
            m_s2[b]  = 1'b0;
            m_db[b]  = 1'b0;
            m_dbd[b] = 1'b0;
            m_run[b] = 0;
        end
        m_state = M_IDLE;
        m_frac  = 0;
        m_secs  = 0;
        m_tick  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        bit raw[2];
        bit ev_ss;
        bit ev_clr;
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = sw_if.btn_start_stop;
        raw[1] = sw_if.btn_clear;
        ev_ss  = m_db[0] && !m_dbd[0];
        ev_clr = m_db[1] && !m_dbd[1];
        for (int b = 0; b < 2; b++) begin
            m_dbd[b] = m_db[b];
            if (m_s2[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DEBOUNCE_CYCLES) begin
                    m_db[b]  = m_s2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        m_tick = 1'b0;
        m_ovf  = 1'b0;
        if (ev_clr) begin
            m_state = M_IDLE;
            m_secs  = 0;
            m_frac  = 0;
        end else begin
            if (m_state == M_RUN) begin
                m_frac++;
                if (m_frac == CLK_HZ) begin
                    m_frac = 0;
                    m_secs++;
                    m_tick = 1'b1;
                    m_ovf  = (m_secs % (MAX_COUNT + 1)) == 0;
                end
            end
            if (ev_ss) begin
                case (m_state)
                    M_IDLE:  begin m_state = M_RUN; m_frac = 0; end
                    M_RUN:   m_state = M_PAUSE;
                    default: m_state = M_RUN;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {15'd0, sw_if.count, sw_if.running, sw_if.paused, sw_if.tick, sw_if.overflow};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [12:0] c;
        c = 13'(m_secs % (MAX_COUNT + 1));
        return {15'd0, c, m_state == M_RUN, m_state == M_PAUSE, m_tick, m_ovf};
    endfunction

    // One clock: model advances at the edge, DUT compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_tick(input int secs, input string tag);
        int  guard;
        bit  found;
        guard = 0;
        found = 1'b0;
        while (!found && guard < 70000) begin
            cycle();
            guard++;
            found = m_tick && (m_secs == secs);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    int ticks_seen;
    int hold_ss;
    int hold_clr;

    initial begin
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        model_reset();
        hold(3);
        check("reset_outputs", dut_vec(), 32'd0);
        rst = 1'b0;
        hold(2);

        // Clean start: raw high before edge k, running at k+6, ticks at k+16, k+26.
        sw_if.btn_start_stop = 1'b1;
        hold(6);
        check("start_k5_running", 32'(sw_if.running), 32'd0);
        cycle();
        check("start_k6_running", 32'(sw_if.running), 32'd1);
        sw_if.btn_start_stop = 1'b0;
        hold(9);
        check("start_k15_tick", 32'(sw_if.tick), 32'd0);
        cycle();
        check("start_k16_tick", 32'(sw_if.tick), 32'd1);
        check("start_k16_count", 32'(sw_if.count), 32'd1);
        hold(10);
        check("start_k26_count", 32'(sw_if.count), 32'd2);

        // Asynchronous reset mid-cycle while running at count 37.
        wait_tick(37, "reach_37");
        hold(3);
        check("pre_rst_count", 32'(sw_if.count), 32'd37);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", dut_vec(), 32'd0);
        model_reset();
        hold(2);
        rst = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            ticks_seen += int'(sw_if.tick);
        end
        check("idle_no_tick", 32'(ticks_seen), 32'd0);

        // Bounce 1,0,1,0 every 2 cycles, then hold high.
        sw_if.btn_start_stop = 1'b1; hold(2);
        sw_if.btn_start_stop = 1'b0; hold(2);
        sw_if.btn_start_stop = 1'b1; hold(2);
        sw_if.btn_start_stop = 1'b0; hold(2);
        sw_if.btn_start_stop = 1'b1;
        hold(6);
        check("bounce_f5_running", 32'(sw_if.running), 32'd0);
        cycle();
        check("bounce_f6_running", 32'(sw_if.running), 32'd1);
        hold(20);
        check("held_single_event", 32'(sw_if.running), 32'd1);
        sw_if.btn_start_stop = 1'b0;
        hold(10);

        // A 3-cycle glitch must not pause the watch.
        sw_if.btn_start_stop = 1'b1; hold(3);
        sw_if.btn_start_stop = 1'b0; hold(12);
        check("glitch_paused", 32'(sw_if.paused), 32'd0);
        check("glitch_running", 32'(sw_if.running), 32'd1);

        // Clear back to IDLE.
        sw_if.btn_clear = 1'b1;
        hold(7);
        check("clear_count", 32'(sw_if.count), 32'd0);
        check("clear_running", 32'(sw_if.running), 32'd0);
        sw_if.btn_clear = 1'b0;
        hold(10);

        // Pause 4 edges after the tick to count 5, then resume.
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        sw_if.btn_start_stop = 1'b0;
        wait_tick(4, "reach_4");
        hold(7);
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        check("pause_paused", 32'(sw_if.paused), 32'd1);
        check("pause_count", 32'(sw_if.count), 32'd5);
        sw_if.btn_start_stop = 1'b0;
        hold(40);
        check("pause_hold_count", 32'(sw_if.count), 32'd5);
        check("pause_hold_paused", 32'(sw_if.paused), 32'd1);
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        check("resume_running", 32'(sw_if.running), 32'd1);
        sw_if.btn_start_stop = 1'b0;
        hold(5);
        check("resume_r5_tick", 32'(sw_if.tick), 32'd0);
        check("resume_r5_count", 32'(sw_if.count), 32'd5);
        cycle();
        check("resume_r6_tick", 32'(sw_if.tick), 32'd1);
        check("resume_r6_count", 32'(sw_if.count), 32'd6);

        // Pause event on the tick edge taking count 9 -> 10.
        wait_tick(9, "reach_9");
        hold(3);
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        check("pause_on_tick", dut_vec(), {15'd0, 13'd10, 1'b0, 1'b1, 1'b1, 1'b0});
        sw_if.btn_start_stop = 1'b0;
        hold(10);

        // Resume, then clear and start/stop in the same cycle.
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        check("resume2_running", 32'(sw_if.running), 32'd1);
        sw_if.btn_start_stop = 1'b0;
        hold(10);
        sw_if.btn_start_stop = 1'b1;
        sw_if.btn_clear      = 1'b1;
        hold(7);
        check("clear_priority", dut_vec(), 32'd0);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        hold(10);

        // Random button activity with varied hold lengths.
        hold_ss  = 0;
        hold_clr = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_ss == 0) begin
                sw_if.btn_start_stop = 1'($urandom_range(0, 1));
                hold_ss = int'($urandom_range(1, 12));
            end
            if (hold_clr == 0) begin
                sw_if.btn_clear = ($urandom_range(0, 5) == 0);
                hold_clr = int'($urandom_range(1, 12));
            end
            hold_ss--;
            hold_clr--;
            cycle();
        end
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_clear      = 1'b0;
        hold(10);

        // Wrap from MAX_COUNT back to 0.
        sw_if.btn_clear = 1'b1;
        hold(7);
        sw_if.btn_clear = 1'b0;
        hold(10);
        sw_if.btn_start_stop = 1'b1;
        hold(7);
        sw_if.btn_start_stop = 1'b0;
        wait_tick(MAX_COUNT, "reach_max");
        check("max_count", 32'(sw_if.count), 32'(MAX_COUNT));
        hold(9);
        check("pre_wrap_tick", 32'(sw_if.tick), 32'd0);
        cycle();
        check("wrap", dut_vec(), {15'd0, 13'd0, 1'b1, 1'b0, 1'b1, 1'b1});
        cycle();
        check("post_wrap", dut_vec(), {15'd0, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        hold(10);
        check("post_wrap_count", 32'(sw_if.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
